// File: rtl/timer_counter.sv
// timer_counter
//
// Memory-mapped 32-bit down-counting timer that sits on the device side of
// the CPU/peripheral bridge in the TC window (0x7F00-0x7F0B). Software
// programs a PRESET value and a CTRL word. The timer then counts PRESET down
// to zero and raises an interrupt request, which the bridge routes to
// HWInt[0].
//
// Register map (selected by Addr[3:2]):
//   0  CTRL   rw  bit0 Enable, bits2:1 Mode, bit3 IM (interrupt mask)
//   1  PRESET rw  reload value
//   2  COUNT  ro  current count
//   3  reserved, reads 0, writes ignored
//
// Optional feature macro: TC_AUTORELOAD_EN
//   defined     : Mode 01 reloads PRESET after every interrupt (periodic).
//   not defined : Mode bits are forced to 0, so every run is one-shot.
//
// Ports:
//   clk    system clock; all state changes on the rising edge
//   reset  asynchronous, active-high; clears all state
//   Addr   bridge byte address; only Addr[3:2] is decoded
//   WE     full-word write strobe from the bridge
//   Din    write data
//   Dout   read data, combinational from Addr[3:2]
//   IRQ    interrupt request = irq_flag & CTRL.IM

module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic [1:0]  reg_sel;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [3:0]  ctrl_wr_data;

    // Word select and write strobes. COUNT and the reserved slot get no
    // strobe at all, which is how writes to them are dropped.
    assign reg_sel   = Addr[3:2];
    assign ctrl_wr   = WE && (reg_sel == SEL_CTRL);
    assign preset_wr = WE && (reg_sel == SEL_PRESET);

    // Without auto-reload support the mode field cannot hold anything but
    // one-shot. It is cleared on the way in, so software reads back 0 there.
`ifdef TC_AUTORELOAD_EN
    assign ctrl_wr_data = Din[3:0];
`else
    assign ctrl_wr_data = {Din[3], 2'b00, Din[0]};
`endif

    // Counter FSM plus the software-visible registers in one block.
    // The CPU write to CTRL comes after the FSM case on purpose. If the INT
    // state clears Enable on the same edge that software writes CTRL, the
    // later non-blocking assignment (the software value) wins.
    // PRESET is only sampled in LOAD. Rewriting it mid-run therefore only
    // affects the next run. A disabled run always goes back through LOAD,
    // so the remaining count is never resumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'h0;
            preset   <= 32'h0;
            count    <= 32'h0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl[0]) begin
                        state    <= LOAD;
                        irq_flag <= 1'b0;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    // A PRESET of 0 falls into the "<= 1" branch straight
                    // away, so it behaves exactly like a PRESET of 1.
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= 32'h0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
`ifdef TC_AUTORELOAD_EN
                    // Auto-reload leaves Enable set, so IDLE reloads at once
                    // and the flag is only a single-cycle pulse.
                    if (ctrl[2:1] == 2'b01) begin
                        irq_flag <= 1'b0;
                    end else begin
                        ctrl[0] <= 1'b0;
                    end
`else
                    ctrl[0] <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (ctrl_wr) begin
                ctrl <= ctrl_wr_data;
            end
            if (preset_wr) begin
                preset <= Din;
            end
        end
    end

    // Zero-latency read mux. Unused CTRL bits and the reserved word read 0.
    always_comb begin
        Dout = 32'h0;
        case (reg_sel)
            SEL_CTRL:   Dout = {28'h0, ctrl};
            SEL_PRESET: Dout = preset;
            SEL_COUNT:  Dout = count;
            default:    Dout = 32'h0;
        endcase
    end

    // IM only gates the output. The flag stays pending underneath, so
    // unmasking later re-exposes it.
    assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter
//
// Directed bench for timer_counter. Each step drives the bridge-side write
// port, then reads registers back and compares them (and IRQ) against values
// worked out by hand from the edge-by-edge timing of the timer.
// Inputs change 1 ns after a rising edge. Outputs are sampled before the
// next rising edge.
// Expectations that depend on TC_AUTORELOAD_EN follow the same macro.

module tb_timer_counter;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int vectors;
    int miscompares;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value against its expected value, counts the
    // comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advances to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bridge write. The rising edge inside this task is the write edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        Addr = addr;
        Din  = data;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        Din  = 32'h0;
    endtask

    // Reads one register through the combinational read port and checks it.
    task automatic checkReg(input string tag, input logic [31:0] addr,
                            input logic [31:0] expected);
        Addr = addr;
        #1;
        checkOutput(tag, Dout, expected);
    endtask

    task automatic checkIrq(input string tag, input logic expected);
        checkOutput(tag, {31'h0, IRQ}, {31'h0, expected});
    endtask

    initial begin
        logic exp_irq;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = 32'h0;
        Din   = 32'h0;

        // Reset state, both during and after reset.
        #1 reset = 1'b1;
        #1;
        checkReg("rst_ctrl",   A_CTRL,   32'h0);
        checkReg("rst_preset", A_PRESET, 32'h0);
        checkReg("rst_count",  A_COUNT,  32'h0);
        checkReg("rst_rsvd",   A_RSVD,   32'h0);
        checkIrq("rst_irq", 1'b0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        checkReg("post_rst_ctrl",   A_CTRL,   32'h0);
        checkReg("post_rst_preset", A_PRESET, 32'h0);
        checkReg("post_rst_count",  A_COUNT,  32'h0);
        checkReg("post_rst_rsvd",   A_RSVD,   32'h0);
        checkIrq("post_rst_irq", 1'b0);

        // COUNT and the reserved word ignore writes. Addr[1:0] is not decoded.
        applyStimulus(A_COUNT, 32'h55);
        applyStimulus(A_RSVD, 32'hAA);
        checkReg("count_ro", A_COUNT, 32'h0);
        checkReg("rsvd_ro",  A_RSVD,  32'h0);
        applyStimulus(A_PRESET, 32'h1234_5678);
        checkReg("preset_alias", A_PRESET | 32'h3, 32'h1234_5678);

        // One-shot run with PRESET=5: COUNT reads 5..0 after E2..E7.
        applyStimulus(A_PRESET, 32'd5);
        applyStimulus(A_CTRL, 32'h9);
        tick();
        checkIrq("os_e1_irq", 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkReg($sformatf("os_count_e%0d", i + 2), A_COUNT, 32'(5 - i));
            checkIrq($sformatf("os_irq_e%0d", i + 2), i == 5);
        end
        tick();
        checkReg("os_ctrl_e8", A_CTRL, 32'h8);
        checkIrq("os_irq_e8", 1'b1);
        tick();
        tick();
        checkIrq("os_irq_hold", 1'b1);

        // Auto-reload PRESET=3 (one-shot when the feature is absent).
        applyStimulus(A_PRESET, 32'd3);
        applyStimulus(A_CTRL, 32'hB);
        checkIrq("ar_e0_irq_pending", 1'b1);
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef TC_AUTORELOAD_EN
            exp_irq = (k == 5) || (k == 11) || (k == 17);
`else
            exp_irq = (k >= 5);
`endif
            checkIrq($sformatf("ar_irq_e%0d", k), exp_irq);
        end
`ifdef TC_AUTORELOAD_EN
        checkReg("ar_ctrl", A_CTRL, 32'hB);
`else
        checkReg("ar_ctrl", A_CTRL, 32'h8);
`endif
        applyStimulus(A_CTRL, 32'h0);
        tick();
        tick();
        checkIrq("ar_stopped_irq", 1'b0);

        // Masked one-shot with PRESET=10: the flag sets while IRQ stays low.
        applyStimulus(A_PRESET, 32'd10);
        applyStimulus(A_CTRL, 32'h1);
        for (int k = 1; k <= 13; k++) begin
            tick();
            checkIrq($sformatf("mask_irq_e%0d", k), 1'b0);
        end
        checkReg("mask_count", A_COUNT, 32'h0);
        checkReg("mask_ctrl",  A_CTRL,  32'h0);
        applyStimulus(A_CTRL, 32'h8);
        checkIrq("unmask_irq", 1'b1);
        applyStimulus(A_CTRL, 32'h0);
        checkIrq("remask_irq", 1'b0);
        applyStimulus(A_CTRL, 32'h8);
        checkIrq("reunmask_irq", 1'b1);

        // Rewriting PRESET mid-run only affects the next LOAD.
        applyStimulus(A_PRESET, 32'd8);
        applyStimulus(A_CTRL, 32'h9);
        repeat (6) tick();
        checkReg("mid_count_4", A_COUNT, 32'd4);
        applyStimulus(A_PRESET, 32'd100);
        checkReg("mid_count_3", A_COUNT, 32'd3);
        tick();
        checkReg("mid_count_2", A_COUNT, 32'd2);
        tick();
        checkReg("mid_count_1", A_COUNT, 32'd1);
        checkIrq("mid_irq_e9", 1'b0);
        tick();
        checkReg("mid_count_0", A_COUNT, 32'd0);
        checkIrq("mid_irq_e10", 1'b1);
        checkReg("mid_preset", A_PRESET, 32'd100);
        tick();
        checkReg("mid_ctrl_done", A_CTRL, 32'h8);
        applyStimulus(A_CTRL, 32'h9);
        checkIrq("reen_e0_irq", 1'b1);
        tick();
        checkIrq("reen_e1_irq", 1'b0);
        tick();
        checkReg("reen_count_100", A_COUNT, 32'd100);

        // Disable mid-count: COUNT holds, then a re-enable reloads PRESET=0.
        tick();
        applyStimulus(A_CTRL, 32'h0);
        tick();
        checkReg("dis_count_hold", A_COUNT, 32'd98);
        applyStimulus(A_PRESET, 32'd0);
        applyStimulus(A_CTRL, 32'h9);
        tick();
        tick();
        checkReg("p0_count_reload", A_COUNT, 32'd0);
        checkIrq("p0_irq_e2", 1'b0);
        tick();
        checkIrq("p0_irq_e3", 1'b1);
        tick();
        checkReg("p0_ctrl", A_CTRL, 32'h8);

        // Asynchronous reset at COUNT=2.
        applyStimulus(A_PRESET, 32'd4);
        applyStimulus(A_CTRL, 32'h9);
        repeat (4) tick();
        checkReg("pre_rst_count", A_COUNT, 32'd2);
        #1 reset = 1'b1;
        #1;
        checkReg("async_rst_count",  A_COUNT,  32'h0);
        checkReg("async_rst_ctrl",   A_CTRL,   32'h0);
        checkReg("async_rst_preset", A_PRESET, 32'h0);
        checkIrq("async_rst_irq", 1'b0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkIrq($sformatf("after_rst_irq_%0d", k), 1'b0);
        end
        checkReg("after_rst_ctrl",   A_CTRL,   32'h0);
        checkReg("after_rst_preset", A_PRESET, 32'h0);
        checkReg("after_rst_count",  A_COUNT,  32'h0);
        checkReg("after_rst_rsvd",   A_RSVD,   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
